latch_wr_ctrl: RTL and testbench

Synchronous write controller for a bank of level-sensitive latches with clear/preset. Accepts write, clear and preset commands over a valid/ready handshake. Drives glitch-free registered data, enable, clear and preset strobes with programmable setup, pulse-width and hold intervals. Sits between clocked fabric logic and a latch bank such as the iCE40 latch primitives.

---
 rtl/latch_wr_ctrl.sv | 132 +++++++++++++
 tb/tb_latch_wr_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/latch_wr_ctrl.sv
// latch_wr_ctrl: write/clear/preset sequencer for a bank of level-sensitive
// latches. It accepts one command at a time over valid/ready. For each
// command it drives a registered data bus and one registered strobe, with
// setup, pulse and hold intervals set by parameters.
//
// Optional feature: define LATCH_READBACK_EN to add the lat_q/mismatch
// ports and a readback compare. The compare runs on the last HOLD cycle.
module latch_wr_ctrl #(
  parameter int WIDTH        = 8,
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 2,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_data,
  output logic [WIDTH-1:0] lat_d,
  output logic             lat_en,
  output logic             lat_clr,
  output logic             lat_pre,
  output logic             busy,
  output logic             done
`ifdef LATCH_READBACK_EN
  ,
  input  logic [WIDTH-1:0] lat_q,
  output logic             mismatch
`endif
);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_CLR = 2'b01;
  localparam logic [1:0] OP_PRE = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  // One down-counter serves all three intervals, so it is sized for the longest.
  localparam int MAX_A   = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int MAX_CYC = (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_q;

  // Sequencer: every output is a flop, so the latch strobes cannot glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= OP_WR;
      lat_d     <= '0;
      lat_en    <= 1'b0;
      lat_clr   <= 1'b0;
      lat_pre   <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (req_valid && req_ready) begin
            op_q <= req_op;
            case (req_op)
              OP_WR:   lat_d <= req_data;
              OP_CLR:  lat_d <= '0;
              OP_PRE:  lat_d <= '1;
              default: lat_d <= lat_d;
            endcase
            cnt       <= SETUP_LD;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            lat_en  <= (op_q == OP_WR);
            lat_clr <= (op_q == OP_CLR);
            lat_pre <= (op_q == OP_PRE);
            cnt     <= PULSE_LD;
            state   <= PULSE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            lat_en  <= 1'b0;
            lat_clr <= 1'b0;
            lat_pre <= 1'b0;
            cnt     <= HOLD_LD;
            state   <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            done      <= 1'b1;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LATCH_READBACK_EN
  // Sticky readback check: lat_d still holds the expected value during HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch <= 1'b0;
    end else if (state == HOLD && cnt == '0 && op_q != OP_RSV && lat_q != lat_d) begin
      mismatch <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_latch_wr_ctrl.sv
// tb_latch_wr_ctrl: directed vector bench for latch_wr_ctrl.
// Build with LATCH_READBACK_EN defined to also cover the readback compare.
module tb_latch_wr_ctrl;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic [1:0] req_op;
  logic [7:0] req_data;
  logic       req_ready;
  logic [7:0] lat_d;
  logic       lat_en, lat_clr, lat_pre, busy, done;

  logic       v2;
  logic [1:0] op2;
  logic [7:0] d2;
  logic       ready2;
  logic [7:0] lat_d2;
  logic       en2, clr2, pre2, busy2, done2;

`ifdef LATCH_READBACK_EN
  logic [7:0] lat_q;
  logic [7:0] lat_mem;
  logic       mismatch;
  logic       stuck;
  logic       mismatch2;
`endif

  int checks = 0;
  int errors = 0;

  latch_wr_ctrl #(.WIDTH(8), .SETUP_CYCLES(1), .PULSE_CYCLES(2), .HOLD_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data), .lat_d(lat_d), .lat_en(lat_en),
    .lat_clr(lat_clr), .lat_pre(lat_pre), .busy(busy), .done(done)
`ifdef LATCH_READBACK_EN
    , .lat_q(lat_q), .mismatch(mismatch)
`endif
  );

  latch_wr_ctrl #(.WIDTH(8), .SETUP_CYCLES(3), .PULSE_CYCLES(1), .HOLD_CYCLES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_ready(ready2),
    .req_op(op2), .req_data(d2), .lat_d(lat_d2), .lat_en(en2),
    .lat_clr(clr2), .lat_pre(pre2), .busy(busy2), .done(done2)
`ifdef LATCH_READBACK_EN
    , .lat_q(lat_d2), .mismatch(mismatch2)
`endif
  );

`ifdef LATCH_READBACK_EN
  // Behavioural latch bank; the stuck mode forces bit 2 low.
  always_latch begin
    if (!rst_n)       lat_mem = 8'h00;
    else if (lat_clr) lat_mem = 8'h00;
    else if (lat_pre) lat_mem = 8'hFF;
    else if (lat_en)  lat_mem = lat_d;
  end
  assign lat_q = stuck ? (lat_mem & 8'hFB) : lat_mem;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] op;
    logic [7:0] d;
    logic [7:0] ed;
    logic [5:0] fl;  // {en, clr, pre, ready, busy, done}
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic v, input logic [1:0] op, input logic [7:0] d,
                     input logic [7:0] ed, input logic [5:0] fl);
    vec_t r;
    r.v = v; r.op = op; r.d = d; r.ed = ed; r.fl = fl;
    tbl.push_back(r);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] ed, input logic [5:0] fl);
    chk8({tag, " lat_d"}, lat_d, ed);
    chk1({tag, " lat_en"}, lat_en, fl[5]);
    chk1({tag, " lat_clr"}, lat_clr, fl[4]);
    chk1({tag, " lat_pre"}, lat_pre, fl[3]);
    chk1({tag, " req_ready"}, req_ready, fl[2]);
    chk1({tag, " busy"}, busy, fl[1]);
    chk1({tag, " done"}, done, fl[0]);
  endtask

`ifdef LATCH_READBACK_EN
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] d);
    int n;
    req_valid = 1'b1; req_op = op; req_data = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk1("cmd done within bound", done, 1'b1);
  endtask
`endif

  initial begin
    logic seen_done;
    rst_n = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_data = 8'h00;
    v2 = 1'b0; op2 = 2'b00; d2 = 8'h00;
`ifdef LATCH_READBACK_EN
    stuck = 1'b0;
`endif

    // Directed per-cycle vectors: rows are applied before an edge, checked after it.
    row(1'b1, 2'b00, 8'hA5, 8'hA5, 6'b000010);  // accept write A5
    row(1'b0, 2'b00, 8'h00, 8'hA5, 6'b100010);
    row(1'b0, 2'b00, 8'h00, 8'hA5, 6'b100010);
    row(1'b0, 2'b00, 8'h00, 8'hA5, 6'b000010);
    row(1'b0, 2'b00, 8'h00, 8'hA5, 6'b000101);  // done at T+4
    row(1'b0, 2'b00, 8'h00, 8'hA5, 6'b000100);
    row(1'b1, 2'b01, 8'h77, 8'h00, 6'b000010);  // accept clear
    row(1'b1, 2'b01, 8'h77, 8'h00, 6'b010010);
    row(1'b1, 2'b10, 8'h77, 8'h00, 6'b010010);
    row(1'b1, 2'b10, 8'h77, 8'h00, 6'b000010);
    row(1'b1, 2'b10, 8'h77, 8'h00, 6'b000101);  // clear done
    row(1'b1, 2'b10, 8'h77, 8'hFF, 6'b000010);  // preset accepted on done cycle
    row(1'b0, 2'b00, 8'h00, 8'hFF, 6'b001010);
    row(1'b0, 2'b00, 8'h00, 8'hFF, 6'b001010);
    row(1'b0, 2'b00, 8'h00, 8'hFF, 6'b000010);
    row(1'b0, 2'b00, 8'h00, 8'hFF, 6'b000101);
    row(1'b1, 2'b11, 8'h12, 8'hFF, 6'b000010);  // reserved op
    row(1'b0, 2'b00, 8'h00, 8'hFF, 6'b000010);
    row(1'b0, 2'b00, 8'h00, 8'hFF, 6'b000010);
    row(1'b0, 2'b00, 8'h00, 8'hFF, 6'b000010);
    row(1'b0, 2'b00, 8'h00, 8'hFF, 6'b000101);
    row(1'b0, 2'b00, 8'h00, 8'hFF, 6'b000100);

    // Reset state, asynchronously and after release.
    #2 rst_n = 1'b0;
    #1 chk_all("reset async", 8'h00, 6'b000100);
    #19 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all("idle after reset", 8'h00, 6'b000100);
`ifdef LATCH_READBACK_EN
    chk1("mismatch reset", mismatch, 1'b0);
`endif

    foreach (tbl[i]) begin
      req_valid = tbl[i].v; req_op = tbl[i].op; req_data = tbl[i].d;
      @(posedge clk); #1;
      chk_all($sformatf("row%0d", i), tbl[i].ed, tbl[i].fl);
    end
    req_valid = 1'b0;
`ifdef LATCH_READBACK_EN
    chk1("mismatch after good ops", mismatch, 1'b0);
`endif

    // Reset during PULSE of a write drops the strobe without a clock edge.
    req_valid = 1'b1; req_op = 2'b00; req_data = 8'h5A;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk1("pre-abort lat_en", lat_en, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk1("abort lat_en", lat_en, 1'b0);
    chk8("abort lat_d", lat_d, 8'h00);
    chk1("abort req_ready", req_ready, 1'b1);
    chk1("abort busy", busy, 1'b0);
    #1 rst_n = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    chk1("abort no done", seen_done, 1'b0);
    chk1("abort ready after release", req_ready, 1'b1);

    // SETUP=3, PULSE=1, HOLD=2 instance: strobe at T+3, done at T+6.
    v2 = 1'b1; op2 = 2'b00; d2 = 8'hC3;
    @(posedge clk); #1;
    v2 = 1'b0; d2 = 8'h00;
    chk8("p2 lat_d", lat_d2, 8'hC3);
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      chk1($sformatf("p2 en k%0d", k), en2, (k == 3));
      chk1($sformatf("p2 done k%0d", k), done2, (k == 6));
      chk1($sformatf("p2 busy k%0d", k), busy2, (k < 6));
      chk1($sformatf("p2 ready k%0d", k), ready2, (k >= 6));
      chk1($sformatf("p2 clr/pre k%0d", k), clr2 | pre2, 1'b0);
    end
    chk8("p2 lat_d held", lat_d2, 8'hC3);

`ifdef LATCH_READBACK_EN
    chk1("p2 mismatch", mismatch2, 1'b0);
    stuck = 1'b0;
    run_cmd(2'b00, 8'h3C);
    @(posedge clk); #1;
    chk1("readback good", mismatch, 1'b0);
    stuck = 1'b1;
    run_cmd(2'b00, 8'h3C);
    @(posedge clk); #1;
    chk1("readback stuck", mismatch, 1'b1);
    stuck = 1'b0;
    run_cmd(2'b00, 8'h3C);
    @(posedge clk); #1;
    chk1("readback sticky", mismatch, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
